// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational field decode feeding a 2-entry output FIFO.
// Optional macro DECODE_ILLEGAL_TRAP_EN flags unrecognised encodings on out_illegal.
module decode_stage #(
  parameter int XLEN = 32,
  localparam int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic [STRB_W-1:0] out_write_strb,
  output logic              out_is_load,
  output logic              out_illegal
);

  // Handshake: a record moves across a port on any rising edge where valid && ready.
  // in_ready depends only on occupancy and reset, never on in_valid.

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;

  typedef struct packed {
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic              reg_write;
    logic [STRB_W-1:0] strb;
    logic              is_load;
    logic              illegal;
  } rec_t;

  rec_t        dec;
  rec_t        head;
  rec_t        skid;
  logic [1:0]  count;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm32;
  logic        known, wr_class, load_ok, store_ok, is_load;
  logic [STRB_W-1:0] strb;
  logic        accept, retire;

  always_comb begin
    op    = in_instr[6:0];
    f3    = in_instr[14:12];
    rd_f  = in_instr[11:7];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};

    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: load_ok = 1'b1;
      3'd3, 3'd6:                   load_ok = (XLEN == 64);
      default:                      load_ok = 1'b0;
    endcase
    store_ok = (f3 <= 3'd2) || ((f3 == 3'd3) && (XLEN == 64));

    strb = '0;
    case (f3)
      3'd0:    strb = STRB_W'(8'h01);
      3'd1:    strb = STRB_W'(8'h03);
      3'd2:    strb = STRB_W'(8'h0F);
      3'd3:    strb = STRB_W'(8'hFF);
      default: strb = '0;
    endcase

    known    = 1'b1;
    wr_class = 1'b0;
    is_load  = 1'b0;
    imm32    = '0;
    dec      = '0;
    case (op)
      OPC_OP:  wr_class = 1'b1;
      OPC_IMM, OPC_JALR: begin
        wr_class = 1'b1;
        imm32    = imm_i;
      end
      OPC_LOAD: begin
        if (load_ok) begin
          wr_class = 1'b1;
          is_load  = 1'b1;
          imm32    = imm_i;
        end else begin
          known = 1'b0;
        end
      end
      OPC_STORE: begin
        if (store_ok) imm32 = imm_s;
        else          known = 1'b0;
      end
      OPC_BRANCH: imm32 = imm_b;
      OPC_JAL: begin
        wr_class = 1'b1;
        imm32    = imm_j;
      end
      OPC_AUIPC, OPC_LUI: begin
        wr_class = 1'b1;
        imm32    = imm_u;
      end
      OPC_OP32: begin
        if (XLEN == 64) wr_class = 1'b1;
        else            known    = 1'b0;
      end
      OPC_IMM32: begin
        if (XLEN == 64) begin
          wr_class = 1'b1;
          imm32    = imm_i;
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase

    // Unrecognised encodings collapse to an all-zero record (a NOP).
    dec.imm       = XLEN'($signed(imm32));
    dec.rd        = wr_class ? rd_f : 5'd0;
    dec.reg_write = known && wr_class && (rd_f != 5'd0);
    dec.strb      = (known && op == OPC_STORE) ? strb : '0;
    dec.is_load   = is_load;
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal   = !known;
`else
    dec.illegal   = 1'b0;
`endif
  end

  assign in_ready  = !reset && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  // head is the visible output register; skid holds the younger record.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (accept) begin
            head  <= dec;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && retire) begin
            head <= dec;
          end else if (retire) begin
            count <= 2'd0;
          end else if (accept) begin
            skid  <= dec;
            count <= 2'd2;
          end
        end
        2'd2: begin
          if (retire) begin
            head  <= skid;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign out_imm        = head.imm;
  assign out_rd         = head.rd;
  assign out_reg_write  = head.reg_write;
  assign out_write_strb = head.strb;
  assign out_is_load    = head.is_load;
  assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share one input stream;
// vector table, randomized queue-model run, and hand-written FIFO corner sequences.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        ir32, ov32, rw32, ld32, il32;
  logic [31:0] imm32;
  logic [4:0]  rd32;
  logic [3:0]  strb32;
  logic        ir64, ov64, rw64, ld64, il64;
  logic [63:0] imm64;
  logic [4:0]  rd64;
  logic [7:0]  strb64;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_rd(rd32), .out_reg_write(rw32), .out_write_strb(strb32),
    .out_is_load(ld32), .out_illegal(il32)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_rd(rd64), .out_reg_write(rw64), .out_write_strb(strb64),
    .out_is_load(ld64), .out_illegal(il64)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    longint imm;
    int     rd;
    bit     rw;
    int     strb;
    bit     ld;
    bit     ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  strb;
    logic        ld;
    logic        ill;
  } vec_t;

  // Reference decode from the ISA field definitions, using signed shifts.
  function automatic exp_t model(input logic [31:0] ins, input int xlen);
    exp_t   e;
    longint s;
    int     f3, rdf;
    bit     wr, ok;
    e   = '{imm: 0, rd: 0, rw: 0, strb: 0, ld: 0, ill: 0};
    s   = longint'($signed(ins));
    f3  = int'(ins[14:12]);
    rdf = int'(ins[11:7]);
    wr  = 0;
    ok  = 1;
    case (ins[6:0])
      7'h33: wr = 1;
      7'h13, 7'h67: begin wr = 1; e.imm = s >>> 20; end
      7'h03: if (f3 inside {0, 1, 2, 4, 5} || (xlen == 64 && f3 inside {3, 6})) begin
               wr = 1; e.ld = 1; e.imm = s >>> 20;
             end else ok = 0;
      7'h23: if (f3 <= 2 || (xlen == 64 && f3 == 3)) begin
               e.imm  = ((s >>> 25) <<< 5) | ((s >> 7) & 31);
               e.strb = (1 << (1 << f3)) - 1;
             end else ok = 0;
      7'h63: e.imm = ((s >>> 31) <<< 12) | (((s >> 7) & 1) << 11) |
                     (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1);
      7'h6F: begin
               wr = 1;
               e.imm = ((s >>> 31) <<< 20) | (((s >> 12) & 255) << 12) |
                       (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1);
             end
      7'h17, 7'h37: begin wr = 1; e.imm = s & -64'sd4096; end
      7'h3B: if (xlen == 64) wr = 1; else ok = 0;
      7'h1B: if (xlen == 64) begin wr = 1; e.imm = s >>> 20; end else ok = 0;
      default: ok = 0;
    endcase
    e.rw  = wr && (rdf != 0);
    e.rd  = wr ? rdf : 0;
    e.ill = !ok && TRAP;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [31:0] ins);
    exp_t e;
    e = model(ins, 32);
    check({tag, " imm32"}, {32'b0, imm32}, {32'b0, e.imm[31:0]});
    check({tag, " rd32"}, 64'(rd32), 64'(e.rd));
    check({tag, " rw32"}, 64'(rw32), 64'(e.rw));
    check({tag, " strb32"}, 64'(strb32), 64'(e.strb));
    check({tag, " ld32"}, 64'(ld32), 64'(e.ld));
    check({tag, " ill32"}, 64'(il32), 64'(e.ill));
    e = model(ins, 64);
    check({tag, " imm64"}, imm64, 64'(e.imm));
    check({tag, " rd64"}, 64'(rd64), 64'(e.rd));
    check({tag, " rw64"}, 64'(rw64), 64'(e.rw));
    check({tag, " strb64"}, 64'(strb64), 64'(e.strb));
    check({tag, " ld64"}, 64'(ld64), 64'(e.ld));
    check({tag, " ill64"}, 64'(il64), 64'(e.ill));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37,
            7'h3B, 7'h1B, 7'h00};
    r = $urandom();
    ops[11] = r[6:0];
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"sh",      32'h00C712A3, 32'h00000005, 5'd0,  1'b0, 4'h3, 1'b0, 1'b0};
    tbl[1]  = '{"bgeu",    32'hFE0FFEE3, 32'hFFFFFFFC, 5'd0,  1'b0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{"lw",      32'h005EAE03, 32'h00000005, 5'd28, 1'b1, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{"lui",     32'h800004B7, 32'h80000000, 5'd9,  1'b1, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{"addi",    32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1'b1, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{"add_x0",  32'h00000033, 32'h00000000, 5'd0,  1'b0, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{"jal",     32'h008000EF, 32'h00000008, 5'd1,  1'b1, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{"sw",      32'h00112223, 32'h00000004, 5'd0,  1'b0, 4'hF, 1'b0, 1'b0};
    tbl[8]  = '{"sd_rv32", 32'h00113023, 32'h00000000, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1};
    tbl[9]  = '{"opc_7f",  32'h0000007F, 32'h00000000, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{"op32_32", 32'h000002BB, 32'h00000000, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1};
    tbl[11] = '{"lwu_32",  32'h00006003, 32'h00000000, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    step();
    step();
    check("reset out_valid", 64'({ov32, ov64}), 64'd0);
    check("reset in_ready", 64'({ir32, ir64}), 64'd0);
    check("reset imm", imm64 | {32'b0, imm32}, 64'd0);
    check("reset fields", 64'({rd32, rw32, strb32, ld32, il32, rd64, rw64, strb64, ld64, il64}), 64'd0);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", 64'({ir32, ir64}), 64'h3);

    // Vector table, one instruction per cycle with the output always drained.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_instr = tbl[i].instr;
      in_valid = 1'b1;
      step();
      check({tbl[i].name, " valid"}, 64'(ov32), 64'd1);
      check({tbl[i].name, " imm"}, 64'(imm32), 64'(tbl[i].imm));
      check({tbl[i].name, " rd"}, 64'(rd32), 64'(tbl[i].rd));
      check({tbl[i].name, " rw"}, 64'(rw32), 64'(tbl[i].rw));
      check({tbl[i].name, " strb"}, 64'(strb32), 64'(tbl[i].strb));
      check({tbl[i].name, " ld"}, 64'(ld32), 64'(tbl[i].ld));
      check({tbl[i].name, " ill"}, 64'(il32), 64'(tbl[i].ill && TRAP));
      check_rec(tbl[i].name, tbl[i].instr);
    end
    in_valid = 1'b0;
    step();
    check("table drained", 64'({ov32, ov64}), 64'd0);

    // Randomized traffic against an in-order queue of accepted instructions.
    for (int c = 0; c < 400; c++) begin
      bit acc, ret;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = rand_instr();
      #1;
      check("rand in_ready", 64'({ir32, ir64}), (exp_q.size() < 2) ? 64'h3 : 64'h0);
      check("rand out_valid", 64'({ov32, ov64}), (exp_q.size() != 0) ? 64'h3 : 64'h0);
      if (exp_q.size() != 0) check_rec("rand", exp_q[0]);
      acc = in_valid && (exp_q.size() < 2);
      ret = out_ready && (exp_q.size() != 0);
      step();
      if (flush) exp_q.delete();
      else begin
        if (ret) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(in_instr);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rand drained", 64'({ov32, ov64}), 64'd0);

    // Back-pressure: three loads, skid fills, order preserved on release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h005EAE03;
    #1;
    check("bp in_ready empty", 64'(ir32), 64'd1);
    step();
    check("bp first out", 64'({ov32, rd32, ld32}), 64'({1'b1, 5'd28, 1'b1}));
    in_instr = 32'h005EAE83;
    step();
    check("bp full in_ready", 64'({ir32, ir64}), 64'd0);
    in_instr = 32'h005EAF03;
    step();
    check("bp hold rd", 64'({ov32, rd32, ld32}), 64'({1'b1, 5'd28, 1'b1}));
    check("bp hold imm", 64'(imm32), 64'd5);
    out_ready = 1'b1;
    #1;
    check("bp full+ready in_ready", 64'(ir32), 64'd0);
    step();
    check("bp second out", 64'({ov32, rd32, ld32}), 64'({1'b1, 5'd29, 1'b1}));
    check("bp in_ready reopens", 64'(ir32), 64'd1);
    step();
    check("bp third out", 64'({ov32, rd32, ld32}), 64'({1'b1, 5'd30, 1'b1}));
    in_valid = 1'b0;
    step();
    check("bp empty", 64'(ov32), 64'd0);

    // Flush with two held and one offered: nothing survives.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush out_valid", 64'({ov32, ov64}), 64'd0);
    check("flush in_ready", 64'({ir32, ir64}), 64'h3);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush stays empty", 64'({ov32, ov64}), 64'd0);
    end

    // RV64 U-type sign extension and unknown opcode on the wide instance.
    in_valid = 1'b1;
    in_instr = 32'h800004B7;
    step();
    check("lui64 imm", imm64, 64'hFFFFFFFF80000000);
    check("lui64 rd", 64'({rw64, rd64}), 64'({1'b1, 5'd9}));
    in_instr = 32'h0000007F;
    step();
    check("opc7f64 ill", 64'({il64, rw64, strb64}), 64'({TRAP, 1'b0, 8'h00}));
    in_valid = 1'b0;
    step();

    // Reset with one record held discards it.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00C712A3;
    step();
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    check("midreset out_valid", 64'({ov32, ov64}), 64'd0);
    check("midreset in_ready", 64'({ir32, ir64}), 64'd0);
    reset = 1'b0;
    #1;
    check("midreset release in_ready", 64'({ir32, ir64}), 64'h3);
    out_ready = 1'b1;
    step();
    check("midreset nothing emerges", 64'({ov32, ov64}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter STRB_W, default XLEN/8, store byte-strobe width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all held and incoming instructions.
REQ-006 SHALL have port in_valid  input  1  in_instr is valid.
REQ-007 SHALL have port in_ready  output  1  stage accepts an instruction this cycle.
REQ-008 SHALL have port in_instr  input  32  raw RV32I/RV64I instruction word.
REQ-009 SHALL have port out_valid  output  1  decoded record is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the record this cycle.
REQ-011 SHALL have port out_imm  output  XLEN  signed immediate, sign-extended to XLEN.
REQ-012 SHALL have port out_rd  output  5  destination register index.
REQ-013 SHALL have port out_reg_write  output  1  record writes out_rd.
REQ-014 SHALL have port out_write_strb  output  STRB_W  store byte enables, LSB = lowest byte.
REQ-015 SHALL have port out_is_load  output  1  record is a LOAD.
REQ-016 SHALL have port out_illegal  output  1  unrecognised opcode/funct3.

Function
REQ-017 SHALL decode opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111; with XLEN=64 also OP-32 0111011 and OP-IMM-32 0011011.
REQ-018 SHALL form immediates: I-type for OP-IMM/OP-IMM-32/LOAD/JALR, S-type for STORE, B-type for BRANCH, J-type for JAL, U-type for LUI/AUIPC; out_imm 0 for OP/OP-32.
REQ-019 SHALL sign-extend every immediate from instr[31] to XLEN regardless of funct3, including BLTU/BGEU and U-type on XLEN=64.
REQ-020 SHALL drive out_reg_write 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC (and -32 forms) only when instr[11:7] != 0; else 0.
REQ-021 SHALL set out_write_strb for STORE by funct3: 000 -> 0x01, 001 -> 0x03, 010 -> 0x0F, 011 -> 0xFF (XLEN=64 only); all other cases 0.
REQ-022 SHALL register decode results: a record accepted at edge N SHALL appear on outputs after edge N (1-cycle latency) when the output slot is free.
REQ-023 SHALL hold a 2-entry FIFO (output register + skid entry); in_ready = 1 when fewer than 2 entries held, independent of in_valid.
REQ-024 SHALL accept on in_valid && in_ready and retire on out_valid && out_ready; simultaneous accept and retire with 2 entries impossible (in_ready 0), with 1 entry SHALL keep occupancy 1 and advance order.
REQ-025 SHALL hold out_* stable while out_valid && !out_ready.
REQ-026 SHALL preserve program order; skid entry SHALL move to the output register on the retire edge.
REQ-027 flush SHALL empty both entries at the next edge, drop any instruction offered that cycle, and take precedence over accept/retire.
REQ-028 With 2 entries, out_ready=1 and in_valid=1, in_ready SHALL be 0 that cycle; the input is accepted the following cycle.

Reset
REQ-029 While reset is 1 at an edge: out_valid=0, occupancy=0, out_imm=0, out_rd=0, out_reg_write=0, out_write_strb=0, out_is_load=0, out_illegal=0.
REQ-030 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion; reset mid-stream SHALL discard held records without retiring them.

Configuration
REQ-031 Macro DECODE_ILLEGAL_TRAP_EN defined: unrecognised opcodes, invalid STORE/LOAD funct3, and SD on XLEN=32 SHALL set out_illegal=1 with out_reg_write=0 and out_write_strb=0.
REQ-032 Macro DECODE_ILLEGAL_TRAP_EN undefined: out_illegal SHALL be tied 0 and such instructions SHALL pass as NOPs (reg_write 0, strb 0, imm 0).

Verification
REQ-033 XLEN=32, out_ready=1, instr 0x00C712A3 -> next cycle out_valid=1, out_write_strb=0x3, out_imm=5, out_reg_write=0.
REQ-034 XLEN=32, BGEU 0xFE0FFEE3 -> out_imm=0xFFFFFFFC (sign-extended), out_reg_write=0.
REQ-035 out_ready=0, feed 3 back-to-back LOADs 0x005EAE03 -> first two accepted, in_ready=0 on third; raise out_ready -> records emerge in order, out_is_load=1, out_rd=28.
REQ-036 2 entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emerges later.
REQ-037 XLEN=64, LUI 0x800004B7 -> out_imm=0xFFFFFFFF80000000, out_rd=9; with DECODE_ILLEGAL_TRAP_EN, opcode 0x7F -> out_illegal=1, out_reg_write=0.
REQ-038 Assert reset with 1 entry held -> after edge out_valid=0, in_ready=0; deassert -> in_ready=1 next cycle.
